// File: rtl/s_cpu_cycle_trace.sv
// Per-instruction cycle trace recorder: pushes {opcode, cycles, sat, lost} records into a FIFO.
// Optional opcode filter is compiled in with S_CPU_TRACE_FILTER_EN (adds op_match/op_mask ports).
module s_cpu_cycle_trace #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cpu_en,
  input  logic                     state_opfetch,
  input  logic [7:0]               op,
  input  logic                     clear,
`ifdef S_CPU_TRACE_FILTER_EN
  input  logic [7:0]               op_match,
  input  logic [7:0]               op_mask,
`endif
  output logic                     rd_valid,
  output logic [15:0]              rd_data,
  input  logic                     rd_ack,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [4:0]    ctr_q, ctr_d;
  logic [7:0]    op_reg_q, op_reg_d;
  logic          armed_q, armed_d;
  logic          lost_pend_q, lost_pend_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [15:0]   mem_q [DEPTH];

  logic          fetch, filter_ok, push_req, pop, full, empty, push_ok, drop;
  logic [4:0]    cycles;
  logic [15:0]   entry;

  // Read port handshake: rd_valid means the head entry is on rd_data; an rd_ack
  // seen at a clock edge while rd_valid=1 pops that entry, otherwise it is ignored.
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_valid = ~empty;
  assign rd_data  = empty ? 16'h0000 : mem_q[rd_ptr_q[AW-1:0]];
  assign level    = wr_ptr_q - rd_ptr_q;

  assign fetch = cpu_en & state_opfetch;

`ifdef S_CPU_TRACE_FILTER_EN
  assign filter_ok = ((op_reg_q & op_mask) == (op_match & op_mask));
`else
  assign filter_ok = 1'b1;
`endif

  // The record describes the instruction that just ended, so it uses the old op_reg/ctr.
  assign push_req = fetch & armed_q & filter_ok;
  assign pop      = rd_ack & ~empty;
  assign push_ok  = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;
  assign cycles   = (ctr_q == 5'd31) ? 5'd31 : ctr_q + 5'd1;
  assign entry    = {op_reg_q, cycles, (ctr_q == 5'd31), lost_pend_q, 1'b0};

  always_comb begin
    ctr_d       = ctr_q;
    op_reg_d    = op_reg_q;
    armed_d     = armed_q;
    lost_pend_d = lost_pend_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;

    if (cpu_en) begin
      if (state_opfetch) begin
        ctr_d    = 5'd0;
        op_reg_d = op;
      end else if (ctr_q != 5'd31) begin
        ctr_d = ctr_q + 5'd1;
      end
    end

    // clear flushes the FIFO and disarms but leaves the cycle counter and opcode running.
    if (clear) begin
      armed_d     = 1'b0;
      lost_pend_d = 1'b0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
    end else begin
      armed_d  = armed_q | fetch;
      wr_ptr_d = wr_ptr_q + (AW+1)'(push_ok);
      rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
      if (drop) begin
        lost_pend_d = 1'b1;
      end else if (push_ok) begin
        lost_pend_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctr_q       <= 5'd0;
      op_reg_q    <= 8'h00;
      armed_q     <= 1'b0;
      lost_pend_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      ctr_q       <= ctr_d;
      op_reg_q    <= op_reg_d;
      armed_q     <= armed_d;
      lost_pend_q <= lost_pend_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  // Storage needs no reset: rd_data is gated by rd_valid.
  always_ff @(posedge clk) begin
    if (push_ok && !clear) begin
      mem_q[wr_ptr_q[AW-1:0]] <= entry;
    end
  end

endmodule

// File: tb/tb_s_cpu_cycle_trace.sv
// Directed bench for s_cpu_cycle_trace (DEPTH=4) with hand-computed trace records.
module tb_s_cpu_cycle_trace;

  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cpu_en = 1'b0;
  logic          state_opfetch = 1'b0;
  logic [7:0]    op = 8'h00;
  logic          clear = 1'b0;
  logic          rd_ack = 1'b0;
  logic          rd_valid;
  logic [15:0]   rd_data;
  logic [LW-1:0] level;
`ifdef S_CPU_TRACE_FILTER_EN
  logic [7:0]    op_match = 8'h00;
  logic [7:0]    op_mask = 8'h00;
`endif

  int checks = 0;
  int failures = 0;

  s_cpu_cycle_trace #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .cpu_en        (cpu_en),
    .state_opfetch (state_opfetch),
    .op            (op),
    .clear         (clear),
`ifdef S_CPU_TRACE_FILTER_EN
    .op_match      (op_match),
    .op_mask       (op_mask),
`endif
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .rd_ack        (rd_ack),
    .level         (level)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock with the given inputs; outputs are settled 1ns after the edge.
  task automatic step(input logic en, input logic of, input logic [7:0] opc,
                      input logic ack, input logic clr);
    cpu_en        = en;
    state_opfetch = of;
    op            = opc;
    rd_ack        = ack;
    clear         = clr;
    @(posedge clk);
    #1;
    cpu_en        = 1'b0;
    state_opfetch = 1'b0;
    rd_ack        = 1'b0;
    clear         = 1'b0;
  endtask

  task automatic fetch(input logic [7:0] opc);
    step(1'b1, 1'b1, opc, 1'b0, 1'b0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
  endtask

  // Disabled clocks with opfetch high and junk opcode: must be invisible.
  task automatic gap(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
  endtask

  task automatic pop_check(input string tag, input logic [15:0] exp);
    check_eq({tag, "_valid"}, {31'd0, rd_valid}, 32'd1);
    check_eq({tag, "_data"}, {16'd0, rd_data}, {16'd0, exp});
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    #1;
    reset = 1'b1;
    #1;
    check_eq("rst_valid", {31'd0, rd_valid}, 32'd0);
    check_eq("rst_data", {16'd0, rd_data}, 32'd0);
    check_eq("rst_level", {{(32-LW){1'b0}}, level}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    // reset values
    do_reset();

    // basic counting
    fetch(8'hE8); run(1); fetch(8'h00); run(1); fetch(8'h11);
    check_eq("basic_level", {{(32-LW){1'b0}}, level}, 32'd2);
    pop_check("basic_e0", 16'hE810);
    pop_check("basic_e1", 16'h0010);
    check_eq("basic_empty_valid", {31'd0, rd_valid}, 32'd0);
    check_eq("basic_empty_data", {16'd0, rd_data}, 32'd0);

    // clock-enable gaps
    do_reset();
    fetch(8'hE8); gap(3); run(1); gap(3); fetch(8'h00); gap(3); run(1); gap(3); fetch(8'h11);
    gap(3);
    check_eq("gap_level", {{(32-LW){1'b0}}, level}, 32'd2);
    pop_check("gap_e0", 16'hE810);
    pop_check("gap_e1", 16'h0010);

    // push while empty with ack: ack ignored, push lands
    do_reset();
    fetch(8'h55); run(1); step(1'b1, 1'b1, 8'h66, 1'b1, 1'b0);
    check_eq("empty_pp_level", {{(32-LW){1'b0}}, level}, 32'd1);
    pop_check("empty_pp_e0", 16'h5510);

    // reset mid-instruction leaves no partial entry and disarms
    fetch(8'h77); run(3);
    do_reset();
    fetch(8'h88);
    check_eq("midrst_level", {{(32-LW){1'b0}}, level}, 32'd0);
    run(1); fetch(8'h99);
    pop_check("midrst_e0", 16'h8810);

    // overflow: 6 instructions into 4 entries, then ack and one more push
    do_reset();
    fetch(8'hA0);
    for (int i = 1; i <= 6; i++) begin
      run(1); fetch(8'(8'hA0 + i));
    end
    check_eq("ovf_level", {{(32-LW){1'b0}}, level}, 32'd4);
    pop_check("ovf_e0", 16'hA010);
    run(1); fetch(8'hA7);
    check_eq("ovf_level2", {{(32-LW){1'b0}}, level}, 32'd4);
    pop_check("ovf_e1", 16'hA110);
    pop_check("ovf_e2", 16'hA210);
    pop_check("ovf_e3", 16'hA310);
    pop_check("ovf_tail_lost", 16'hA612);

    // saturation boundaries: 40, 30 and 31 extra cycles
    do_reset();
    fetch(8'h9E); run(40); fetch(8'h00); run(30); fetch(8'h01); run(31); fetch(8'h02);
    check_eq("sat_level", {{(32-LW){1'b0}}, level}, 32'd3);
    pop_check("sat_40", 16'h9EFC);
    pop_check("sat_30", 16'h00F8);
    pop_check("sat_31", 16'h01FC);

    // full with simultaneous push and pop, then clear together with a push
    do_reset();
    fetch(8'hB0);
    for (int i = 1; i <= 4; i++) begin
      run(1); fetch(8'(8'hB0 + i));
    end
    check_eq("fpp_full_level", {{(32-LW){1'b0}}, level}, 32'd4);
    run(1); step(1'b1, 1'b1, 8'hB5, 1'b1, 1'b0);
    check_eq("fpp_level", {{(32-LW){1'b0}}, level}, 32'd4);
    check_eq("fpp_head", {16'd0, rd_data}, 32'h0000B110);
    run(1); step(1'b1, 1'b1, 8'hC0, 1'b0, 1'b1);
    check_eq("clr_level", {{(32-LW){1'b0}}, level}, 32'd0);
    check_eq("clr_valid", {31'd0, rd_valid}, 32'd0);
    check_eq("clr_data", {16'd0, rd_data}, 32'd0);
    run(1); fetch(8'hC1);
    check_eq("clr_rearm_level", {{(32-LW){1'b0}}, level}, 32'd0);
    run(1); fetch(8'hC2);
    check_eq("clr_push_level", {{(32-LW){1'b0}}, level}, 32'd1);
    pop_check("clr_e0", 16'hC110);

`ifdef S_CPU_TRACE_FILTER_EN
    // filter: only opcode 3F passes
    do_reset();
    op_match = 8'h3F;
    op_mask  = 8'hFF;
    fetch(8'h3F); run(1); fetch(8'h00); run(1); fetch(8'h3F); run(1); fetch(8'h00);
    run(1); fetch(8'h3F);
    check_eq("flt_level", {{(32-LW){1'b0}}, level}, 32'd2);
    pop_check("flt_e0", 16'h3F10);
    pop_check("flt_e1", 16'h3F10);
    op_mask = 8'h00;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
